// File: rtl/fetch_queue_ifu.sv
// Instruction fetch unit: credit-limited memory request issue, in-order response queue,
// and decode-stage redirect with drop accounting for stale in-flight responses.
module fetch_queue_ifu #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] PC_START = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4,
   output logic [31:0] out_pc8,
   output logic [31:0] out_instr,
   input  logic        redir_valid,
   input  logic [1:0]  npc_op,
   input  logic        branch,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] reg_data,
   input  logic [31:0] base_pc
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] One = CW'(1);

   logic [63:0]   fifo_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW:0]   inflight;
   logic [31:0]   target;
   logic          fire, accept, push, pop;

   always_comb begin
      fire   = 1'b0;
      target = '0;
      if (redir_valid) begin
         unique case (npc_op)
            2'b01: begin
               fire   = branch;
               target = base_pc + {{14{imm16[15]}}, imm16, 2'b00};
            end
            2'b10: begin
               fire   = 1'b1;
               target = {base_pc[31:28], imm26, 2'b00};
            end
            2'b11: begin
               fire   = 1'b1;
               target = {reg_data[31:2], 2'b00};
            end
            default: ;
         endcase
      end
   end

   // Every queued entry and every in-flight request holds a slot, so a push never overflows.
   assign inflight  = {1'b0, count_q} + {1'b0, outst_q};
   assign req_valid = ~reset & en & ~fire & (inflight < (CW+1)'(DEPTH));
   assign req_addr  = fetch_pc_q;
   assign accept    = req_valid & req_ready;

   assign out_valid = ~reset & (count_q != '0);
   assign out_pc    = fifo_q[rd_ptr_q][63:32];
   assign out_instr = fifo_q[rd_ptr_q][31:0];
   assign out_pc4   = out_pc + 32'd4;
   assign out_pc8   = out_pc + 32'd8;

   assign push = rsp_valid & (drop_q == '0) & ~fire;
   assign pop  = out_valid & out_ready & ~fire;

   always_comb begin
      outst_d    = outst_q;
      drop_d     = drop_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;

      unique case ({accept, rsp_valid})
         2'b10:   outst_d = outst_q + One;
         2'b01:   outst_d = outst_q - One;
         default: outst_d = outst_q;
      endcase

      if (fire) begin
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = target;
         rsp_pc_d   = target;
         // Pending drops are a subset of outstanding; whatever is still in flight after
         // this cycle belongs to the old path and must be discarded.
         drop_d     = outst_d;
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_valid && drop_q != '0) drop_d = drop_q - One;
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop) count_d = count_q + One;
         else if (pop && !push) count_d = count_q - One;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         fetch_pc_q <= PC_START;
         rsp_pc_q   <= PC_START;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {rsp_pc_q, rsp_data};
   end

endmodule

// File: tb/tb_fetch_queue_ifu.sv
// Scoreboard bench for fetch_queue_ifu: a latency-configurable memory model answers requests,
// expected PCs are queued on issue and compared against every instruction popped at the head.
module tb_fetch_queue_ifu;

   localparam logic [31:0] PC_START = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, out_ready = 1'b0;
   logic        redir_valid = 1'b0, branch = 1'b0;
   logic [1:0]  npc_op = 2'b00;
   logic [15:0] imm16 = '0;
   logic [25:0] imm26 = '0;
   logic [31:0] reg_data = '0, base_pc = '0, rsp_data = '0;
   logic        req_valid, out_valid;
   logic [31:0] req_addr, out_pc, out_pc4, out_pc8, out_instr;

   fetch_queue_ifu #(.DEPTH(4), .PC_START(PC_START)) u_dut (
      .clk(clk), .reset(reset), .en(en),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8), .out_instr(out_instr),
      .redir_valid(redir_valid), .npc_op(npc_op), .branch(branch), .imm16(imm16),
      .imm26(imm26), .reg_data(reg_data), .base_pc(base_pc)
   );

   always #5 clk = ~clk;

   int          n_vec = 0, n_err = 0;
   int          cyc = 0, lat = 1, n_acc = 0, n_pop = 0;
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc = PC_START;
   logic [31:0] exp_target = '0;
   logic [31:0] last_pop_pc = '0;
   bit          exp_fire = 1'b0;

   function automatic logic [31:0] ifn(logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive the memory response, score at the falling edge, advance.
   task automatic step();
      logic [31:0] e;
      if (!reset && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = ifn(mem_addr_q[0]);
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
      @(negedge clk);
      if (reset) begin
         check_eq("rst_req_valid", req_valid, 0);
         check_eq("rst_out_valid", out_valid, 0);
      end else begin
         if (rsp_valid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
         end
         if (!en || exp_fire) check_eq("req_blocked", req_valid, 0);
         if (exp_fire) begin
            exp_q.delete();
            exp_pc = exp_target;
         end else begin
            if (req_valid && req_ready) begin
               check_eq("req_addr", req_addr, exp_pc);
               exp_q.push_back(exp_pc);
               mem_addr_q.push_back(req_addr);
               mem_due_q.push_back(cyc + lat);
               exp_pc += 32'd4;
               n_acc++;
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check_eq("pop_unexpected", out_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("out_pc", out_pc, e);
                  check_eq("out_pc4", out_pc4, e + 32'd4);
                  check_eq("out_pc8", out_pc8, e + 32'd8);
                  check_eq("out_instr", out_instr, ifn(e));
               end
               last_pop_pc = out_pc;
               n_pop++;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_q.delete();
      exp_pc = PC_START;
      run(2);
      reset = 1'b0;
      check_eq("rst_req_addr", req_addr, PC_START);
      check_eq("rst_out_empty", out_valid, 0);
   endtask

   task automatic redirect(logic [1:0] op, logic br, logic [15:0] i16, logic [25:0] i26,
                           logic [31:0] rd, logic [31:0] bp, bit fires, logic [31:0] tgt,
                           int ncyc);
      redir_valid = 1'b1;
      npc_op = op; branch = br; imm16 = i16; imm26 = i26; reg_data = rd; base_pc = bp;
      exp_fire = fires;
      exp_target = tgt;
      run(ncyc);
      redir_valid = 1'b0;
      npc_op = 2'b00;
      exp_fire = 1'b0;
   endtask

   task automatic wait_pop(string tag, logic [31:0] tgt, int budget);
      int p0 = n_pop;
      for (int i = 0; i < budget && n_pop == p0; i++) step();
      check_eq({tag, "_seen"}, n_pop > p0, 1);
      check_eq(tag, last_pop_pc, tgt);
   endtask

   initial begin
      int a0;
      do_reset();

      // Free-running stream with a 1-cycle memory.
      en = 1'b1; req_ready = 1'b1; out_ready = 1'b1; lat = 1;
      wait_pop("stream_first", 32'h0000_3000, 10);
      run(20);

      // Back-pressure: the queue fills to DEPTH, then drains one per cycle.
      do_reset();
      en = 1'b1; req_ready = 1'b1; out_ready = 1'b0; lat = 1;
      a0 = n_acc;
      run(10);
      check_eq("full_accepts", n_acc - a0, 4);
      check_eq("full_req_valid", req_valid, 0);
      check_eq("full_out_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("drain_valid", out_valid, 1);
         step();
      end
      a0 = n_acc;
      run(8);
      check_eq("resume_req", n_acc > a0, 1);

      // Jump with three stale responses in flight.
      do_reset();
      en = 1'b1; req_ready = 1'b1; out_ready = 1'b1; lat = 3;
      run(12);
      redirect(2'b10, 1'b0, 16'h0, 26'h0000_100, 32'h0, 32'h0000_3008, 1'b1,
               32'h0000_0400, 1);
      wait_pop("jump_target", 32'h0000_0400, 20);
      run(6);

      // Not-taken branch leaves the stream alone; taken branch goes backwards.
      lat = 2;
      run(6);
      redirect(2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3010, 1'b0, 32'h0, 1);
      run(6);
      redirect(2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3010, 1'b1,
               32'h0000_3008, 1);
      wait_pop("branch_target", 32'h0000_3008, 20);
      run(4);

      // Register redirect held for two cycles.
      redirect(2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3013, 32'h0, 1'b1, 32'h0000_3010, 2);
      wait_pop("reg_target", 32'h0000_3010, 20);
      run(6);

      // Fetch disabled with responses still pending.
      lat = 3;
      run(4);
      en = 1'b0; out_ready = 1'b0;
      run(5);
      check_eq("en_off_queued", out_valid, 1);
      out_ready = 1'b1;
      run(4);
      en = 1'b1;
      run(6);

      // Randomised handshakes, latencies and register redirects.
      for (int i = 0; i < 300; i++) begin
         req_ready = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if (i % 40 == 0) lat = $urandom_range(1, 4);
         if ($urandom_range(0, 24) == 0) begin
            logic [31:0] r = $urandom;
            redirect(2'b11, 1'b0, 16'h0, 26'h0, r, 32'h0, 1'b1, {r[31:2], 2'b00},
                     $urandom_range(1, 2));
         end else begin
            step();
         end
      end

      // Reset in the middle of traffic, then restart from PC_START.
      req_ready = 1'b1; out_ready = 1'b1; lat = 2;
      run(3);
      do_reset();
      wait_pop("restart_first", PC_START, 12);

      // Drain everything still outstanding.
      en = 1'b0;
      for (int i = 0; i < 40 && (exp_q.size() > 0 || mem_addr_q.size() > 0); i++) step();
      run(2);
      check_eq("drain_lost", exp_q.size(), 0);
      check_eq("drain_out_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
